spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one SPI master.
REQ-002 Parameter TIMEOUT_CYC, default 96: maximum clk cycles from m_start to m_done before abort.
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req  in  N_REQ  per-requester transfer request, level.
REQ-006 wdata  in  N_REQ x 8  per-requester byte to transmit.
REQ-007 lock  in  N_REQ  per-requester hold-grant flag for multi-byte bursts.
REQ-008 gnt  out  N_REQ  one-hot grant; at most one bit set.
REQ-009 rdata  out  8  received byte; valid only with rvalid.
REQ-010 rvalid  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 err  out  N_REQ  one-cycle timeout pulse to the granted requester.
REQ-012 m_start  out  1  start pulse to the SPI master.
REQ-013 m_tx_data  out  8  byte to the SPI master.
REQ-014 m_rx_data  in  8  byte received by the SPI master.
REQ-015 m_busy  in  1  SPI master busy.
REQ-016 m_done  in  1  SPI master one-cycle done pulse.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP; IDLE is the only state in which arbitration occurs.
REQ-018 IDLE, any req high and m_busy low: select the winner round-robin, first set req bit at or above pointer ptr, wrapping N_REQ-1 to 0; latch index and wdata; set gnt[index]; go to START.
REQ-019 IDLE with m_busy high: no grant; remain in IDLE.
REQ-020 START: m_start high for exactly one cycle with m_tx_data equal to the latched byte; clear the timeout counter; go to WAIT.
REQ-021 m_tx_data holds the latched byte from START until leaving WAIT; it is 0 otherwise.
REQ-022 WAIT: the counter increments each cycle; on m_done, latch m_rx_data into rdata and go to RESP.
REQ-023 WAIT: when the counter reaches TIMEOUT_CYC-1 without m_done, pulse err[index] for one cycle, clear gnt, leave rdata unchanged, advance ptr to index+1 mod N_REQ, and go to IDLE.
REQ-024 m_done and the timeout in the same cycle: m_done wins.
REQ-025 RESP: rvalid[index] high for one cycle with rdata stable; clear gnt; go to IDLE.
REQ-026 RESP with lock[index] high: ptr = index. Otherwise ptr = (index+1) mod N_REQ.
REQ-027 Under lock, the same requester is regranted at the next IDLE if its req is still high; otherwise normal round-robin applies.
REQ-028 gnt is high from the cycle after the arbitration decision through RESP, inclusive.
REQ-029 req deasserted after grant: the transfer still completes and rvalid or err still pulses.
REQ-030 wdata changes after grant are ignored.
REQ-031 Minimum spacing between two m_start pulses is 4 cycles (START, WAIT of at least 1 cycle, RESP, IDLE).
REQ-032 m_done while not in WAIT is ignored.

Reset
REQ-033 On rst_n low at a clk edge: state=IDLE, ptr=0, gnt=0, rvalid=0, err=0, m_start=0, m_tx_data=0, rdata=0, counter=0.
REQ-034 Reset mid-transfer abandons the transfer; no rvalid or err is issued for it.
REQ-035 The first arbitration after reset starts from requester 0.

Structure
REQ-036 State enum, default N_REQ, and TIMEOUT_CYC live in shared package spi_pkg, alongside the SPI master's CLK_DIV.
REQ-037 Round-robin pick logic (req, ptr -> one-hot winner plus valid) is a combinational sub-module spi_rr_pick.
REQ-038 The block connects directly to the existing SPI master's start, tx_data, rx_data, busy, and done ports.

Verification
REQ-039 Single requester: req[2]=1, wdata[2]=0xA5, slave returns 0x3C -> one m_start with m_tx_data=0xA5; rvalid[2] pulses with rdata=0x3C; gnt[2] then drops.
REQ-040 Contention: req=4'b1111 held, no lock -> grant order 0,1,2,3,0; exactly one gnt bit set per transfer.
REQ-041 Lock: req=4'b0011 with lock[1]=1 for 3 bytes, first winner 1 -> requester 1 is granted 3 consecutive times; requester 0 is granted next after lock[1] drops.
REQ-042 Timeout: the master never asserts m_done -> err[idx] pulses 96 cycles after m_start; rvalid stays 0; the next requester is granted.
REQ-043 Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 the next cycle, no rvalid or err, ptr=0.
REQ-044 m_busy held high with req pending -> no m_start and gnt=0 until m_busy drops.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the arbiter that fronts it.
package spi_pkg;

  localparam int N_REQ_DEFAULT       = 4;
  localparam int TIMEOUT_CYC_DEFAULT = 96;
  localparam int CLK_DIV             = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  // Index width that stays legal when there is only one item.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin pick: first requester at or above the pointer, wrapping to 0.
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0]              i_req,
  input  logic [idx_width(N_REQ)-1:0]   i_ptr,
  output logic [N_REQ-1:0]              o_onehot,
  output logic [idx_width(N_REQ)-1:0]   o_idx,
  output logic                          o_valid
);

  localparam int PW = idx_width(N_REQ);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [PW-1:0]      w_off;
  logic [PW:0]        w_sum;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N_REQ'(w_dbl >> i_ptr);

  always_comb begin
    o_valid = 1'b0;
    w_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_valid = 1'b1;
        w_off   = PW'(k);
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (PW+1)'(N_REQ)) begin
      w_sum = w_sum - (PW+1)'(N_REQ);
    end
    o_idx    = w_sum[PW-1:0];
    o_onehot = o_valid ? (N_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among N_REQ requesters: round-robin grant, optional
// burst lock, and a timeout abort when the master never reports done.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0][7:0]  wdata,
  input  logic [N_REQ-1:0]       lock,
  output logic [N_REQ-1:0]       gnt,
  output logic [7:0]             rdata,
  output logic [N_REQ-1:0]       rvalid,
  output logic [N_REQ-1:0]       err,
  output logic                   m_start,
  output logic [7:0]             m_tx_data,
  input  logic [7:0]             m_rx_data,
  input  logic                   m_busy,
  input  logic                   m_done
);

  localparam int PW = idx_width(N_REQ);
  localparam int CW = idx_width(TIMEOUT_CYC);

  arb_state_t       r_state, w_state_next;
  logic [PW-1:0]    r_ptr, w_ptr_next;
  logic [PW-1:0]    r_idx, w_idx_next;
  logic [7:0]       r_wdata, w_wdata_next;
  logic [7:0]       r_rdata, w_rdata_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [N_REQ-1:0] r_gnt, w_gnt_next;

  logic [N_REQ-1:0] w_pick_onehot;
  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_valid;

  spi_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  function automatic logic [PW-1:0] f_next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_idx   <= w_idx_next;
      r_wdata <= w_wdata_next;
      r_rdata <= w_rdata_next;
      r_cnt   <= w_cnt_next;
      r_gnt   <= w_gnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_idx_next   = r_idx;
    w_wdata_next = r_wdata;
    w_rdata_next = r_rdata;
    w_cnt_next   = r_cnt;
    w_gnt_next   = r_gnt;
    m_start      = 1'b0;
    m_tx_data    = '0;
    rvalid       = '0;
    err          = '0;

    case (r_state)
      ST_IDLE: begin
        // A busy master blocks arbitration entirely.
        if (w_pick_valid && !m_busy) begin
          w_idx_next   = w_pick_idx;
          w_wdata_next = wdata[w_pick_idx];
          w_gnt_next   = w_pick_onehot;
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        m_start      = 1'b1;
        m_tx_data    = r_wdata;
        w_cnt_next   = '0;
        w_state_next = ST_WAIT;
      end

      ST_WAIT: begin
        m_tx_data  = r_wdata;
        w_cnt_next = r_cnt + CW'(1);
        // Done is tested first so it beats a timeout landing on the same cycle.
        if (m_done) begin
          w_rdata_next = m_rx_data;
          w_state_next = ST_RESP;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          err          = r_gnt;
          w_gnt_next   = '0;
          w_ptr_next   = f_next_idx(r_idx);
          w_state_next = ST_IDLE;
        end
      end

      ST_RESP: begin
        rvalid       = r_gnt;
        w_gnt_next   = '0;
        w_ptr_next   = lock[r_idx] ? r_idx : f_next_idx(r_idx);
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign gnt   = r_gnt;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a simple SPI slave model (rx = tx ^ 0x99).
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int N  = 4;
  localparam int TO = 96;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0][7:0] wdata;
  logic [N-1:0]      lock;
  logic [N-1:0]      gnt;
  logic [7:0]        rdata;
  logic [N-1:0]      rvalid;
  logic [N-1:0]      err;
  logic              m_start;
  logic [7:0]        m_tx_data;
  logic [7:0]        m_rx_data;
  logic              m_busy;
  logic              m_done;

  spi_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .lock      (lock),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err),
    .m_start   (m_start),
    .m_tx_data (m_tx_data),
    .m_rx_data (m_rx_data),
    .m_busy    (m_busy),
    .m_done    (m_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] tx;
    bit         is_err;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         cyc       = 0;
  int         start_cyc = -100;
  logic [7:0] last_rx   = 8'h00;
  int         slave_lat = 1;
  bit         drop_en   = 1'b0;
  logic [7:0] drop_tx   = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: answers each start after slave_lat cycles unless told to drop it.
  initial begin
    logic [7:0] tx;
    m_done    = 1'b0;
    m_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_start === 1'b1 && !(drop_en && m_tx_data == drop_tx)) begin
        tx = m_tx_data;
        repeat (slave_lat) @(posedge clk);
        #1;
        m_done    = 1'b1;
        m_rx_data = tx ^ 8'h99;
        @(posedge clk);
        #1;
        m_done    = 1'b0;
        m_rx_data = 8'h00;
      end
    end
  end

  // Monitor: compares every start and every completion against the scoreboard.
  initial begin
    exp_t        e;
    logic [31:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (m_start) begin
          if (exp_q.size() == 0) begin
            check("unexp_start", 32'(1), 32'(0));
          end else begin
            oh = 32'(1) << exp_q[0].idx;
            check("start_gnt", 32'(gnt), oh);
            check("start_tx", 32'(m_tx_data), 32'(exp_q[0].tx));
          end
          check("start_gap", 32'((cyc - start_cyc) >= 4), 32'(1));
          start_cyc = cyc;
        end
        if (|rvalid || |err) begin
          if (exp_q.size() == 0) begin
            check("unexp_done", 32'({rvalid, err}), 32'(0));
          end else begin
            e  = exp_q.pop_front();
            oh = 32'(1) << e.idx;
            check("done_kind", 32'(|err), 32'(e.is_err));
            if (e.is_err) begin
              check("err_vec", 32'(err), oh);
              check("err_rvalid", 32'(rvalid), 32'(0));
              check("err_rdata_kept", 32'(rdata), 32'(last_rx));
              check("err_latency", 32'(cyc - start_cyc), 32'(TO));
              $display("txn idx=%0d tx=%02h TIMEOUT rdata=%02h", e.idx, e.tx, rdata);
            end else begin
              check("rvalid_vec", 32'(rvalid), oh);
              check("rdata", 32'(rdata), 32'(e.tx ^ 8'h99));
              last_rx = rdata;
              $display("txn idx=%0d tx=%02h rdata=%02h", e.idx, e.tx, rdata);
            end
          end
        end
      end
    end
  end

  task automatic push(input int idx, input logic [7:0] tx, input bit is_err);
    exp_t e;
    e.idx    = idx;
    e.tx     = tx;
    e.is_err = is_err;
    exp_q.push_back(e);
  endtask

  // Runs until n completions; drops lock at the given start and req at the last completion.
  task automatic run(input int n, input int lock_drop_start, input int budget);
    int done   = 0;
    int starts = 0;
    int t      = 0;
    while (done < n && t < budget) begin
      @(negedge clk);
      t++;
      if (m_start) begin
        starts++;
        if (starts == lock_drop_start) lock = '0;
      end
      if (|rvalid || |err) begin
        done++;
        if (done == n) req = '0;
      end
    end
    check("run_complete", 32'(done), 32'(n));
    if (done < n) begin
      req = '0;
      exp_q.delete();
    end
    @(negedge clk);
    check("gnt_idle", 32'(gnt), 32'(0));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int t;
    rst_n  = 1'b0;
    req    = '0;
    lock   = '0;
    wdata  = '0;
    m_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_outs", 32'({rvalid, err, m_start}), 32'(0));
    check("rst_tx", 32'(m_tx_data), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 2
    wdata[2] = 8'hA5;
    req      = 4'b0100;
    push(2, 8'hA5, 1'b0);
    run(1, 0, 50);
    check("single_rdata", 32'(rdata), 32'(8'h3C));

    // Reset in the middle of WAIT abandons the transfer
    slave_lat = 50;
    wdata[3]  = 8'h11;
    req       = 4'b1000;
    push(3, 8'h11, 1'b0);
    t = 0;
    while (m_start !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_test_start", 32'(m_start), 32'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_outs", 32'({gnt, rvalid, err, m_start}), 32'(0));
    check("midrst_tx", 32'(m_tx_data), 32'(0));
    check("midrst_rdata", 32'(rdata), 32'(0));
    rst_n   = 1'b1;
    last_rx = 8'h00;
    repeat (60) @(negedge clk);

    // Contention, no lock: 0,1,2,3,0 (also proves ptr restarted at 0)
    slave_lat = 1;
    for (int i = 0; i < N; i++) wdata[i] = 8'h30 + 8'(i);
    req = 4'b1111;
    push(0, 8'h30, 1'b0);
    push(1, 8'h31, 1'b0);
    push(2, 8'h32, 1'b0);
    push(3, 8'h33, 1'b0);
    push(0, 8'h30, 1'b0);
    run(5, 0, 200);

    // Lock on requester 1 for three bytes, then requester 0
    wdata[0] = 8'h10;
    wdata[1] = 8'h21;
    lock     = 4'b0010;
    req      = 4'b0011;
    push(1, 8'h21, 1'b0);
    push(1, 8'h21, 1'b0);
    push(1, 8'h21, 1'b0);
    push(0, 8'h10, 1'b0);
    run(4, 3, 200);

    // Busy master blocks grants
    m_busy   = 1'b1;
    wdata[0] = 8'hC3;
    req      = 4'b0001;
    ok       = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (gnt != '0 || m_start) ok = 1'b0;
    end
    check("busy_hold", 32'(ok), 32'(1));
    push(0, 8'hC3, 1'b0);
    m_busy = 1'b0;
    run(1, 0, 50);

    // Timeout on requester 2, then requester 3 is served
    drop_en  = 1'b1;
    drop_tx  = 8'h5A;
    slave_lat = 2;
    wdata[2] = 8'h5A;
    wdata[3] = 8'h77;
    req      = 4'b1100;
    push(2, 8'h5A, 1'b1);
    push(3, 8'h77, 1'b0);
    run(2, 0, 400);
    drop_en = 1'b0;

    // Done on the very cycle the timeout would fire: done wins
    slave_lat = TO;
    wdata[0]  = 8'hE7;
    req       = 4'b0001;
    push(0, 8'hE7, 1'b0);
    run(1, 0, 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
